sx_cycle_ctrl: RTL and testbench
================================

# sx_cycle_ctrl

Bus-cycle controller for the Am386SX local bus in the southbridge. It samples ADS# and the M/IO#, D/C#, W/R# definition lines, then classifies each cycle. It hands memory and I/O cycles to a single backend target over a req/ack handshake and generates READY# after a per-space minimum wait count. It also drives read data onto the CPU data bus and terminates hung cycles with a timeout.

## Interface
- WAIT_MEM, 1, minimum clks from cycle start to READY# for memory cycles
- WAIT_IO, 3, minimum clks from cycle start to READY# for I/O cycles
- TIMEOUT, 64, clks without tgt_ack before forced termination; must exceed WAIT_MEM and WAIT_IO
- Reset is synchronous and active-high: one clock, `clk`; `reset` is synchronous, active-high.
- clk  in  1  bus clock; every bus input is sampled on its rising edge
- reset  in  1  synchronous, active-high reset
- ads_n  in  1  CPU address strobe, active low
- mio, dc, wr  in  1 each  CPU cycle definition lines
- be_n  in  2  byte enables {BHE#, BLE#}
- addr  in  23  CPU address A[23:1]
- cpu_din  in  16  CPU data bus input
- cpu_dout  out  16  read data toward the CPU
- cpu_doe  out  1  data bus output enable
- ready_n  out  1  READY# to the CPU
- na_n  out  1  NA#; constant 1, no pipelining
- req  out  1  backend request
- req_io  out  1  1 = I/O space, 0 = memory
- req_wr  out  1  1 = write
- req_addr  out  23  latched address
- req_be_n  out  2  latched byte enables
- req_wdata  out  16  equals cpu_din (pass-through)
- tgt_ack  in  1  backend completion; sampled only while req = 1
- tgt_rdata  in  16  read data, valid when tgt_ack = 1
- halt_cycle  out  1  one-clk pulse on a halt/shutdown cycle
- timeout_err  out  1  one-clk pulse on a forced termination

## Operation
- States: IDLE, BUSY, END.
- Cycle classes by {mio, dc, wr}:
  - 1x0 / 1x1: memory read / write (code fetch included).
  - 0x0 / 0x1: I/O read / write, except 000.
  - 000: interrupt acknowledge (INTA).
  - 101: halt/shutdown.
- IDLE, ads_n = 0 sampled:
  - Latch addr, be_n and class into the req_* outputs, clear wcnt, go to BUSY.
  - Memory/I/O cycles: req <= 1.
  - INTA: no req, ack_seen <= 1, rdata <= 16'h0000, wait 0.
  - Halt: no req, ack_seen <= 1, halt_cycle pulses, wait 0.
- BUSY, every clk:
  - wcnt increments, saturating at TIMEOUT.
  - If req and tgt_ack: req <= 0, ack_seen <= 1, and on reads rdata <= tgt_rdata.
  - Else if req and wcnt == TIMEOUT-1: req <= 0, ack_seen <= 1, rdata <= 16'hFFFF, timeout_err pulses.
  - If ack_seen and wcnt >= WAIT(class): ready_n <= 0, go to END.
- END: ready_n <= 1, cpu_doe <= 0, ack_seen <= 0, go to IDLE.
- cpu_doe is 1 on read-class cycles (memory read, I/O read, INTA) from the edge where rdata loads until END exits. cpu_dout = rdata.
- ads_n is ignored outside IDLE.
- If tgt_ack and timeout coincide, the ack wins.
- req stays high until tgt_ack, or until timeout deasserts it. req_* outputs stay stable while req = 1.

## Timing
- Reset values: ready_n = 1, na_n = 1, req = 0, req_io = 0, req_wr = 0, req_addr = 0, req_be_n = 2'b11, cpu_doe = 0, cpu_dout = 0, halt_cycle = 0, timeout_err = 0; state IDLE, wcnt = 0, ack_seen = 0.
- Reset mid-cycle aborts the cycle: all outputs take their reset values on the next edge, and no READY# is issued for the aborted cycle.
- Latencies, with ADS# sampled at edge k:
  - req rises at edge k.
  - An ack sampled at edge k+1 gives ready_n low at edge max(k+2, k+WAIT+1).
  - ready_n is low for exactly one clk.
- Internal cycles (INTA, halt): ready_n low at edge k+1.
- Earliest back-to-back cycle: the next ADS# can be sampled at the edge where END returns to IDLE.
- wcnt is clog2(TIMEOUT+1) bits wide and unsigned.

## Test plan
- Memory read, tgt_ack asserted 1 clk after req, tgt_rdata = 16'hA55A, WAIT_MEM = 1 -> ready_n low at k+2 for 1 clk; cpu_dout = 16'hA55A with cpu_doe = 1; req low from k+1.
- I/O write to addr 23'h000040, ack immediate, WAIT_IO = 3 -> req_io = 1, req_wr = 1; ready_n low at k+4, not earlier; cpu_doe stays 0.
- Memory read, no tgt_ack, TIMEOUT = 64 -> timeout_err pulse at k+64; ready_n low at k+65; cpu_dout = 16'hFFFF.
- Halt cycle ({mio, dc, wr} = 101) -> halt_cycle pulse at k; ready_n low at k+1; req never asserts. INTA -> ready_n at k+1, cpu_dout = 16'h0000.
- reset asserted while req = 1 and waiting -> next edge gives req = 0, ready_n = 1, cpu_doe = 0; a fresh ADS# afterwards completes normally.
- ADS# pulsed low while BUSY -> ignored; a single ready_n pulse for the original cycle.

Source files
------------

// File: rtl/sx_cycle_ctrl.sv
// Am386SX local-bus cycle controller: classifies ADS# cycles, hands mem/IO to one backend, drives READY#.
// Latency: req at ADS# edge k; READY# at max(ack edge + 1, k + WAIT + 1); internal cycles at k + 1.
// Backpressure: req held until tgt_ack or TIMEOUT clks elapse; ADS# ignored until the cycle returns to IDLE.
module sx_cycle_ctrl #(
    parameter int WAIT_MEM = 1,
    parameter int WAIT_IO  = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ads_n,
    input  logic        mio,
    input  logic        dc,
    input  logic        wr,
    input  logic [1:0]  be_n,
    input  logic [22:0] addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_doe,
    output logic        ready_n,
    output logic        na_n,
    output logic        req,
    output logic        req_io,
    output logic        req_wr,
    output logic [22:0] req_addr,
    output logic [1:0]  req_be_n,
    output logic [15:0] req_wdata,
    input  logic        tgt_ack,
    input  logic [15:0] tgt_rdata,
    output logic        halt_cycle,
    output logic        timeout_err
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] L_TO     = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] L_TO_M1  = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] L_WMEM   = WCNT_W'(WAIT_MEM);
    localparam logic [WCNT_W-1:0] L_WIO    = WCNT_W'(WAIT_IO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ENDC = 2'd2
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   r_wait;
    logic                r_ack_seen;
    logic [15:0]         r_rdata;
    logic                r_doe;
    logic                r_ready_n;
    logic                r_req;
    logic                r_req_io;
    logic                r_req_wr;
    logic [22:0]         r_req_addr;
    logic [1:0]          r_req_be_n;
    logic                r_halt;
    logic                r_tout;

    logic                w_is_halt;
    logic                w_is_inta;
    logic [WCNT_W-1:0]   w_wait_new;

    // Cycle classification from the definition lines; halt and INTA complete internally with no wait
    always_comb begin
        w_is_halt  = mio & ~dc & wr;
        w_is_inta  = ~mio & ~dc & ~wr;
        w_wait_new = (w_is_halt | w_is_inta) ? '0 : (mio ? L_WMEM : L_WIO);
    end

    // Bus-cycle FSM: accept ADS# in IDLE, track backend ack/timeout in BUSY, release READY# in END
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wcnt     <= '0;
            r_wait     <= '0;
            r_ack_seen <= 1'b0;
            r_rdata    <= 16'h0000;
            r_doe      <= 1'b0;
            r_ready_n  <= 1'b1;
            r_req      <= 1'b0;
            r_req_io   <= 1'b0;
            r_req_wr   <= 1'b0;
            r_req_addr <= '0;
            r_req_be_n <= 2'b11;
            r_halt     <= 1'b0;
            r_tout     <= 1'b0;
        end else begin
            r_halt <= 1'b0;
            r_tout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!ads_n) begin
                        r_req_addr <= addr;
                        r_req_be_n <= be_n;
                        r_req_io   <= ~mio;
                        r_req_wr   <= wr;
                        r_wcnt     <= '0;
                        r_wait     <= w_wait_new;
                        r_state    <= BUSY;
                        if (w_is_inta) begin
                            // Interrupt acknowledge returns a zero vector without the backend
                            r_ack_seen <= 1'b1;
                            r_rdata    <= 16'h0000;
                            r_doe      <= 1'b1;
                        end else if (w_is_halt) begin
                            r_ack_seen <= 1'b1;
                            r_halt     <= 1'b1;
                        end else begin
                            r_req <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (r_wcnt != L_TO) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    // An ack on the same clk as the timeout takes priority
                    if (r_req && tgt_ack) begin
                        r_req      <= 1'b0;
                        r_ack_seen <= 1'b1;
                        if (!r_req_wr) begin
                            r_rdata <= tgt_rdata;
                            r_doe   <= 1'b1;
                        end
                    end else if (r_req && (r_wcnt == L_TO_M1)) begin
                        r_req      <= 1'b0;
                        r_ack_seen <= 1'b1;
                        r_rdata    <= 16'hFFFF;
                        r_tout     <= 1'b1;
                        if (!r_req_wr) begin
                            r_doe <= 1'b1;
                        end
                    end
                    if (r_ack_seen && (r_wcnt >= r_wait)) begin
                        r_ready_n <= 1'b0;
                        r_state   <= ENDC;
                    end
                end
                ENDC: begin
                    r_ready_n  <= 1'b1;
                    r_doe      <= 1'b0;
                    r_ack_seen <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_dout    = r_rdata;
    assign cpu_doe     = r_doe;
    assign ready_n     = r_ready_n;
    assign na_n        = 1'b1;
    assign req         = r_req;
    assign req_io      = r_req_io;
    assign req_wr      = r_req_wr;
    assign req_addr    = r_req_addr;
    assign req_be_n    = r_req_be_n;
    assign req_wdata   = cpu_din;
    assign halt_cycle  = r_halt;
    assign timeout_err = r_tout;

endmodule

// File: tb/tb_sx_cycle_ctrl.sv
// Directed bench for sx_cycle_ctrl with a queue-based scoreboard.
// Stimulus pushes the expected READY# edge/data and halt/timeout pulse edges.
// A negedge monitor pops and compares whenever the DUT presents one of them.
module tb_sx_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ads_n;
    logic        mio, dc, wr;
    logic [1:0]  be_n;
    logic [22:0] addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_doe;
    logic        ready_n;
    logic        na_n;
    logic        req, req_io, req_wr;
    logic [22:0] req_addr;
    logic [1:0]  req_be_n;
    logic [15:0] req_wdata;
    logic        tgt_ack;
    logic [15:0] tgt_rdata;
    logic        halt_cycle;
    logic        timeout_err;

    sx_cycle_ctrl #(.WAIT_MEM(1), .WAIT_IO(3), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .ads_n(ads_n), .mio(mio), .dc(dc), .wr(wr),
        .be_n(be_n), .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_doe(cpu_doe), .ready_n(ready_n), .na_n(na_n), .req(req),
        .req_io(req_io), .req_wr(req_wr), .req_addr(req_addr), .req_be_n(req_be_n),
        .req_wdata(req_wdata), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata),
        .halt_cycle(halt_cycle), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_no;
        logic [15:0] dout;
        logic        dout_chk;
        logic        doe;
    } exp_t;

    exp_t sb[$];
    int   hq[$];
    int   tq[$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every READY#, halt or timeout pulse must match the head of its queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready_n === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("ready_unexpected", ready_n, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ready_edge", cyc, e.edge_no);
                    chk("ready_doe", cpu_doe, e.doe);
                    if (e.dout_chk) chk("ready_dout", cpu_dout, e.dout);
                end
            end
            if (halt_cycle === 1'b1) begin
                if (hq.size() == 0) chk("halt_unexpected", halt_cycle, 0);
                else chk("halt_edge", cyc, hq.pop_front());
            end
            if (timeout_err === 1'b1) begin
                if (tq.size() == 0) chk("tout_unexpected", timeout_err, 0);
                else chk("tout_edge", cyc, tq.pop_front());
            end
        end
    end

    // Drive ADS# for one clk; returns at the negedge after the sampling edge k
    task automatic start_cycle(input logic m, input logic d, input logic w,
                               input logic [22:0] a, input logic [1:0] b, output int k);
        @(negedge clk);
        ads_n = 1'b0; mio = m; dc = d; wr = w; addr = a; be_n = b;
        k = cyc + 1;
        @(negedge clk);
        ads_n = 1'b1;
    endtask

    initial begin
        int k;
        exp_t e;
        reset = 1'b1; ads_n = 1'b1; mio = 1'b0; dc = 1'b0; wr = 1'b0;
        be_n = 2'b11; addr = '0; cpu_din = '0; tgt_ack = 1'b0; tgt_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_n", ready_n, 1);
        chk("rst_na_n", na_n, 1);
        chk("rst_req", req, 0);
        chk("rst_req_io", req_io, 0);
        chk("rst_req_wr", req_wr, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_be_n", req_be_n, 2'b11);
        chk("rst_cpu_doe", cpu_doe, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_halt", halt_cycle, 0);
        chk("rst_tout", timeout_err, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Memory read, ack one clk after req
        start_cycle(1'b1, 1'b1, 1'b0, 23'h012345, 2'b00, k);
        e = '{edge_no: k + 2, dout: 16'hA55A, dout_chk: 1'b1, doe: 1'b1};
        sb.push_back(e);
        chk("mr_req", req, 1);
        chk("mr_req_io", req_io, 0);
        chk("mr_req_wr", req_wr, 0);
        chk("mr_req_addr", req_addr, 23'h012345);
        chk("mr_req_be_n", req_be_n, 2'b00);
        tgt_ack = 1'b1; tgt_rdata = 16'hA55A;
        @(negedge clk);
        tgt_ack = 1'b0;
        chk("mr_req_low", req, 0);
        repeat (5) @(negedge clk);

        // I/O write to 0x40, ack immediately, READY# no earlier than k+4
        cpu_din = 16'h1234;
        start_cycle(1'b0, 1'b1, 1'b1, 23'h000040, 2'b10, k);
        e = '{edge_no: k + 4, dout: 16'h0000, dout_chk: 1'b0, doe: 1'b0};
        sb.push_back(e);
        chk("iow_req", req, 1);
        chk("iow_req_io", req_io, 1);
        chk("iow_req_wr", req_wr, 1);
        chk("iow_req_addr", req_addr, 23'h000040);
        chk("iow_wdata", req_wdata, 16'h1234);
        tgt_ack = 1'b1;
        @(negedge clk);
        tgt_ack = 1'b0;
        chk("iow_req_low", req, 0);
        chk("iow_doe", cpu_doe, 0);
        repeat (6) @(negedge clk);

        // Memory read with no ack: timeout
        start_cycle(1'b1, 1'b1, 1'b0, 23'h000100, 2'b00, k);
        tq.push_back(k + 64);
        e = '{edge_no: k + 65, dout: 16'hFFFF, dout_chk: 1'b1, doe: 1'b1};
        sb.push_back(e);
        repeat (63) @(negedge clk);
        chk("to_req_held", req, 1);
        @(negedge clk);
        chk("to_req_drop", req, 0);
        repeat (6) @(negedge clk);

        // Halt: internal, no req
        start_cycle(1'b1, 1'b0, 1'b1, 23'h000002, 2'b11, k);
        hq.push_back(k);
        e = '{edge_no: k + 1, dout: 16'h0000, dout_chk: 1'b0, doe: 1'b0};
        sb.push_back(e);
        chk("halt_no_req", req, 0);
        repeat (5) @(negedge clk);

        // INTA: internal, returns zero with data enabled
        start_cycle(1'b0, 1'b0, 1'b0, 23'h000004, 2'b00, k);
        e = '{edge_no: k + 1, dout: 16'h0000, dout_chk: 1'b1, doe: 1'b1};
        sb.push_back(e);
        chk("inta_no_req", req, 0);
        repeat (5) @(negedge clk);

        // Reset mid-cycle while req pending: no READY# for the aborted cycle
        start_cycle(1'b1, 1'b1, 1'b0, 23'h0ABCDE, 2'b01, k);
        @(negedge clk);
        chk("ab_req_pending", req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ab_req", req, 0);
        chk("ab_ready_n", ready_n, 1);
        chk("ab_doe", cpu_doe, 0);
        chk("ab_req_addr", req_addr, 0);
        repeat (3) @(negedge clk);
        start_cycle(1'b1, 1'b1, 1'b1, 23'h000200, 2'b00, k);
        e = '{edge_no: k + 2, dout: 16'h0000, dout_chk: 1'b0, doe: 1'b0};
        sb.push_back(e);
        chk("fresh_req", req, 1);
        chk("fresh_req_wr", req_wr, 1);
        tgt_ack = 1'b1;
        @(negedge clk);
        tgt_ack = 1'b0;
        repeat (5) @(negedge clk);

        // I/O read with a stray ADS# while BUSY; ack sampled at k+2
        start_cycle(1'b0, 1'b1, 1'b0, 23'h000060, 2'b00, k);
        e = '{edge_no: k + 4, dout: 16'hBEEF, dout_chk: 1'b1, doe: 1'b1};
        sb.push_back(e);
        ads_n = 1'b0; mio = 1'b1; wr = 1'b1; addr = 23'h7FFFFF;
        @(negedge clk);
        ads_n = 1'b1;
        chk("stray_addr", req_addr, 23'h000060);
        chk("stray_io", req_io, 1);
        tgt_ack = 1'b1; tgt_rdata = 16'hBEEF;
        @(negedge clk);
        tgt_ack = 1'b0;
        chk("stray_req_low", req, 0);
        repeat (8) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("hq_drained", hq.size(), 0);
        chk("tq_drained", tq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
